// File: rtl/adsr_envelope.sv
// Linear ADSR envelope generator producing a 16-bit scale word (0xFFFF = unity).
// Level updates happen only on the internal sample tick; gate edges take priority over ticks.
module adsr_envelope #(
   parameter int unsigned DIV = 1000
) (
   input  logic        clk48m,
   input  logic        rst_n,
   input  logic        gate,
   input  logic [15:0] attack_rate,
   input  logic [15:0] decay_rate,
   input  logic [15:0] sustain_level,
   input  logic [15:0] release_rate,
   output logic [15:0] scale,
   output logic [2:0]  env_state,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } state_t;

   localparam logic [15:0] LAST = 16'(DIV - 1);

   state_t      state, state_n;
   logic [15:0] cnt;
   logic [15:0] level_n;
   logic [16:0] att_sum;
   logic [16:0] dec_floor;
   logic        gate_d;
   logic        tick;
   logic        rise;
   logic        fall;

   assign tick      = (cnt == LAST);
   assign rise      = gate & ~gate_d;
   assign fall      = ~gate & gate_d;
   assign env_state = state;

   always_ff @(posedge clk48m or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         gate_d <= 1'b0;
         state  <= IDLE;
         scale  <= '0;
         busy   <= 1'b0;
      end else begin
         cnt    <= tick ? '0 : cnt + 16'd1;
         gate_d <= gate;
         state  <= state_n;
         scale  <= level_n;
         busy   <= (state_n != IDLE);
      end
   end

   always_comb begin
      state_n   = state;
      level_n   = scale;
      // 17-bit intermediates so neither the attack sum nor the decay floor can wrap
      att_sum   = {1'b0, scale} + {1'b0, attack_rate};
      dec_floor = {1'b0, sustain_level} + {1'b0, decay_rate};
      if (rise) begin
         state_n = ATTACK;
      end else if (fall) begin
         if (state == ATTACK || state == DECAY || state == SUSTAIN)
            state_n = RELEASE;
      end else if (tick) begin
         unique case (state)
            ATTACK: begin
               if (attack_rate == '0 || att_sum >= 17'h0FFFF) begin
                  level_n = '1;
                  state_n = DECAY;
               end else begin
                  level_n = att_sum[15:0];
               end
            end
            DECAY: begin
               if (decay_rate == '0 || {1'b0, scale} < dec_floor) begin
                  level_n = sustain_level;
                  state_n = SUSTAIN;
               end else begin
                  level_n = scale - decay_rate;
               end
            end
            SUSTAIN: begin
               level_n = sustain_level;
            end
            RELEASE: begin
               if (release_rate == '0 || scale <= release_rate) begin
                  level_n = '0;
                  state_n = IDLE;
               end else begin
                  level_n = scale - release_rate;
               end
            end
            default: begin
               level_n = '0;
               state_n = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed scenarios plus randomized gate/rate
// traffic compared against a cycle-level arithmetic model of the envelope.
module tb_adsr_envelope;

   localparam int unsigned DIV = 4;

   logic        clk48m = 1'b0;
   logic        rst_n = 1'b1;
   logic        gate = 1'b0;
   logic [15:0] attack_rate = '0;
   logic [15:0] decay_rate = '0;
   logic [15:0] sustain_level = '0;
   logic [15:0] release_rate = '0;
   logic [15:0] scale;
   logic [2:0]  env_state;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   // reference model: phase 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
   int m_level = 0;
   int m_st = 0;
   int m_cyc = 0;
   bit m_gd = 1'b0;

   adsr_envelope #(.DIV(DIV)) dut (
      .clk48m(clk48m),
      .rst_n(rst_n),
      .gate(gate),
      .attack_rate(attack_rate),
      .decay_rate(decay_rate),
      .sustain_level(sustain_level),
      .release_rate(release_rate),
      .scale(scale),
      .env_state(env_state),
      .busy(busy)
   );

   always #5 clk48m = ~clk48m;

   always @(posedge clk48m or negedge rst_n) begin
      if (!rst_n) begin
         m_level = 0;
         m_st    = 0;
         m_cyc   = 0;
         m_gd    = 1'b0;
      end else begin
         bit tk, up, dn;
         tk = ((m_cyc % DIV) == DIV - 1);
         up = gate && !m_gd;
         dn = !gate && m_gd;
         if (up) m_st = 1;
         else if (dn) begin
            if (m_st >= 1 && m_st <= 3) m_st = 4;
         end else if (tk) begin
            case (m_st)
               1: if (attack_rate == 0 || m_level + int'(attack_rate) >= 65535) begin
                     m_level = 65535; m_st = 2;
                  end else m_level = m_level + int'(attack_rate);
               2: if (decay_rate == 0 || m_level < int'(sustain_level) + int'(decay_rate)) begin
                     m_level = int'(sustain_level); m_st = 3;
                  end else m_level = m_level - int'(decay_rate);
               3: m_level = int'(sustain_level);
               4: if (release_rate == 0 || m_level <= int'(release_rate)) begin
                     m_level = 0; m_st = 0;
                  end else m_level = m_level - int'(release_rate);
               default: m_level = 0;
            endcase
         end
         m_gd  = gate;
         m_cyc = m_cyc + 1;
      end
   end

   task automatic do_reset();
      gate  = 1'b0;
      rst_n = 1'b0;
      @(negedge clk48m);
      @(negedge clk48m);
      rst_n = 1'b1;
   endtask

   task automatic set_rates(input logic [15:0] a, input logic [15:0] d,
                            input logic [15:0] s, input logic [15:0] r);
      attack_rate = a; decay_rate = d; sustain_level = s; release_rate = r;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (scale !== 16'h0 || env_state !== 3'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_async: scale=%h state=%0d busy=%b, expected 0000/0/0", scale, env_state, busy);
      end
      @(negedge clk48m);
      rst_n = 1'b1;
      repeat (50) begin
         @(negedge clk48m);
         vectors++;
         if (scale !== 16'h0 || env_state !== 3'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: scale=%h state=%0d busy=%b, expected 0000/0/0", scale, env_state, busy);
         end
      end
   endtask

   task automatic test_full_adsr();
      logic [15:0] exp_ad [12] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF, 16'hEFFF, 16'hDFFF,
                                   16'hCFFF, 16'hBFFF, 16'hAFFF, 16'h9FFF, 16'h8FFF, 16'h8000};
      logic [15:0] exp_rel [4] = '{16'h6000, 16'h4000, 16'h2000, 16'h0000};
      logic [15:0] seen[$];
      logic [2:0]  seen_st[$];
      int          t_chg[$];
      logic [15:0] prev;
      do_reset();
      set_rates(16'h4000, 16'h1000, 16'h8000, 16'h2000);
      gate = 1'b1;
      prev = 16'h0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk48m);
         vectors++;
         if (scale !== m_level[15:0] || env_state !== m_st[2:0] || busy !== (m_st != 0)) begin
            miscompares++;
            $display("FAIL adsr_model: scale=%h state=%0d busy=%b, expected %h/%0d/%b",
                     scale, env_state, busy, m_level[15:0], m_st, m_st != 0);
         end
         if (scale !== prev) begin
            seen.push_back(scale); seen_st.push_back(env_state); t_chg.push_back(c); prev = scale;
         end
      end
      vectors++;
      if (seen.size() != 12) begin
         miscompares++;
         $display("FAIL adsr_steps: %0d level changes, expected 12", seen.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            vectors++;
            if (seen[i] !== exp_ad[i]) begin
               miscompares++;
               $display("FAIL adsr_step%0d: scale=%h, expected %h", i, seen[i], exp_ad[i]);
            end
         end
         vectors++;
         if (seen_st[3] !== 3'd2 || seen_st[11] !== 3'd3) begin
            miscompares++;
            $display("FAIL adsr_phase: state at peak=%0d at floor=%0d, expected 2 and 3", seen_st[3], seen_st[11]);
         end
         vectors++;
         if (t_chg[1] - t_chg[0] != DIV || t_chg[2] - t_chg[1] != DIV) begin
            miscompares++;
            $display("FAIL tick_period: spacing %0d,%0d, expected %0d", t_chg[1] - t_chg[0], t_chg[2] - t_chg[1], DIV);
         end
      end
      gate = 1'b0;
      @(negedge clk48m);
      vectors++;
      if (env_state !== 3'd4 || scale !== 16'h8000) begin
         miscompares++;
         $display("FAIL release_enter: state=%0d scale=%h, expected 4/8000", env_state, scale);
      end
      seen.delete();
      prev = scale;
      for (int c = 0; c < 60 && env_state !== 3'd0; c++) begin
         @(negedge clk48m);
         if (scale !== prev) begin seen.push_back(scale); prev = scale; end
      end
      vectors++;
      if (seen.size() != 4) begin
         miscompares++;
         $display("FAIL release_steps: %0d level changes, expected 4", seen.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (seen[i] !== exp_rel[i]) begin
               miscompares++;
               $display("FAIL release_step%0d: scale=%h, expected %h", i, seen[i], exp_rel[i]);
            end
         end
      end
      vectors++;
      if (env_state !== 3'd0 || busy !== 1'b0 || scale !== 16'h0) begin
         miscompares++;
         $display("FAIL release_end: state=%0d busy=%b scale=%h, expected 0/0/0000", env_state, busy, scale);
      end
   endtask

   task automatic test_instant_rates();
      logic [15:0] first;
      do_reset();
      set_rates(16'h0, 16'h0, 16'h1234, 16'h0);
      gate  = 1'b1;
      first = 16'h0;
      repeat (12) begin
         @(negedge clk48m);
         if (first === 16'h0) first = scale;
      end
      vectors++;
      if (first !== 16'hFFFF || scale !== 16'h1234 || env_state !== 3'd3) begin
         miscompares++;
         $display("FAIL instant_attack_decay: first=%h scale=%h state=%0d, expected ffff,1234,3", first, scale, env_state);
      end
      gate = 1'b0;
      for (int c = 0; c < 2 * DIV + 2 && env_state !== 3'd0; c++) begin
         @(negedge clk48m);
         vectors++;
         if (scale !== m_level[15:0] || env_state !== m_st[2:0] || busy !== (m_st != 0)) begin
            miscompares++;
            $display("FAIL instant_release: scale=%h state=%0d busy=%b, expected %h/%0d/%b",
                     scale, env_state, busy, m_level[15:0], m_st, m_st != 0);
         end
      end
      vectors++;
      if (scale !== 16'h0 || env_state !== 3'd0) begin
         miscompares++;
         $display("FAIL instant_idle: scale=%h state=%0d, expected 0000/0", scale, env_state);
      end
   endtask

   task automatic wait_release_6000(input string tag);
      bit hit;
      do_reset();
      set_rates(16'h4000, 16'h1000, 16'h8000, 16'h2000);
      gate = 1'b1;
      repeat (80) @(negedge clk48m);
      gate = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
         @(negedge clk48m);
         hit = (scale === 16'h6000);
      end
      vectors++;
      if (!hit) begin
         miscompares++;
         $display("FAIL %s_timeout: scale=%h state=%0d, expected to reach 6000", tag, scale, env_state);
      end
   endtask

   task automatic test_retrigger();
      bit moved;
      wait_release_6000("retrigger");
      gate = 1'b1;
      @(negedge clk48m);
      vectors++;
      if (env_state !== 3'd1 || scale !== 16'h6000) begin
         miscompares++;
         $display("FAIL retrigger_enter: state=%0d scale=%h, expected 1/6000", env_state, scale);
      end
      moved = 1'b0;
      for (int c = 0; c < 2 * DIV && !moved; c++) begin
         @(negedge clk48m);
         moved = (scale !== 16'h6000);
      end
      vectors++;
      if (scale !== 16'hA000 || env_state !== 3'd1) begin
         miscompares++;
         $display("FAIL retrigger_climb: scale=%h state=%0d, expected a000/1", scale, env_state);
      end
   endtask

   task automatic test_collision();
      wait_release_6000("collision");
      for (int c = 0; c < DIV && (m_cyc % DIV) != DIV - 1; c++) @(negedge clk48m);
      gate = 1'b1;
      @(negedge clk48m);
      vectors++;
      if (env_state !== 3'd1 || scale !== 16'h6000) begin
         miscompares++;
         $display("FAIL collision_edge: state=%0d scale=%h, expected 1/6000", env_state, scale);
      end
      repeat (DIV - 1) @(negedge clk48m);
      vectors++;
      if (scale !== 16'h6000) begin
         miscompares++;
         $display("FAIL collision_hold: scale=%h, expected 6000", scale);
      end
      @(negedge clk48m);
      vectors++;
      if (scale !== 16'hA000) begin
         miscompares++;
         $display("FAIL collision_next_tick: scale=%h, expected a000", scale);
      end
   endtask

   task automatic test_saturation_sustain();
      bit done;
      do_reset();
      set_rates(16'hFFFF, 16'h1000, 16'h8000, 16'h2000);
      gate = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 3 * DIV && !done; c++) begin
         @(negedge clk48m);
         done = (scale !== 16'h0);
      end
      vectors++;
      if (scale !== 16'hFFFF || env_state !== 3'd2) begin
         miscompares++;
         $display("FAIL attack_saturate: scale=%h state=%0d, expected ffff/2", scale, env_state);
      end
      for (int c = 0; c < 200 && env_state !== 3'd3; c++) @(negedge clk48m);
      vectors++;
      if (scale !== 16'h8000 || env_state !== 3'd3) begin
         miscompares++;
         $display("FAIL sustain_reach: scale=%h state=%0d, expected 8000/3", scale, env_state);
      end
      sustain_level = 16'h3000;
      done = 1'b0;
      for (int c = 0; c < 2 * DIV && !done; c++) begin
         @(negedge clk48m);
         done = (scale !== 16'h8000);
      end
      vectors++;
      if (scale !== 16'h3000 || env_state !== 3'd3) begin
         miscompares++;
         $display("FAIL sustain_track: scale=%h state=%0d, expected 3000/3", scale, env_state);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_rates(16'h0100, 16'h1000, 16'h8000, 16'h2000);
      gate = 1'b1;
      repeat (30) @(negedge clk48m);
      vectors++;
      if (env_state !== 3'd1 || scale !== m_level[15:0]) begin
         miscompares++;
         $display("FAIL midattack: state=%0d scale=%h, expected 1/%h", env_state, scale, m_level[15:0]);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (scale !== 16'h0 || env_state !== 3'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: scale=%h state=%0d busy=%b, expected 0000/0/0", scale, env_state, busy);
      end
      @(negedge clk48m);
      rst_n = 1'b1;
      @(negedge clk48m);
      vectors++;
      if (env_state !== 3'd1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL gate_high_at_release: state=%0d busy=%b, expected 1/1", env_state, busy);
      end
      gate = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      set_rates(16'h2000, 16'h0800, 16'h6000, 16'h1000);
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 39) == 0) gate = ~gate;
         if ($urandom_range(0, 99) == 0)
            attack_rate = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
         if ($urandom_range(0, 99) == 0)
            decay_rate = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
         if ($urandom_range(0, 99) == 0)
            release_rate = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
         if ($urandom_range(0, 149) == 0) sustain_level = 16'($urandom_range(0, 16'hFFFF));
         @(negedge clk48m);
         vectors++;
         if (scale !== m_level[15:0] || env_state !== m_st[2:0] || busy !== (m_st != 0)) begin
            miscompares++;
            $display("FAIL random_c%0d: scale=%h state=%0d busy=%b, expected %h/%0d/%b",
                     c, scale, env_state, busy, m_level[15:0], m_st, m_st != 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_adsr();
      test_instant_rates();
      test_retrigger();
      test_collision();
      test_saturation_sustain();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
